// File: rtl/proc_pkg.sv
// Shared processor types and sizing for the register file and its neighbours
// (decode write-register-select mux, decoder).
package proc_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned REG_N  = 8;
  localparam int unsigned NUM_W  = $clog2(REG_N);

  typedef logic [NUM_W-1:0]  reg_num_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef data_t [REG_N-1:0] reg_array_t;

  // True when a read must be served from the write-back stage instead of the array.
  function automatic logic stage_hit(input logic valid, input reg_num_t stg_num,
                                     input reg_num_t rd_num);
    return valid && (stg_num == rd_num);
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Register-file bus: two read ports, one write port and the condition-flag update.
// The core side is the master; the register file is the slave.
interface register_file_if;
  import proc_pkg::*;

  reg_num_t rd_a_num;
  reg_num_t rd_b_num;
  data_t    rd_a_data;
  data_t    rd_b_data;
  logic     wr_en;
  reg_num_t wr_num;
  data_t    wr_data;
  logic     flag_we;
  logic     flag_in;
  logic     flag_out;
  logic     wb_pending;

  modport master (
    output rd_a_num, rd_b_num, wr_en, wr_num, wr_data, flag_we, flag_in,
    input  rd_a_data, rd_b_data, flag_out, wb_pending
  );

  modport slave (
    input  rd_a_num, rd_b_num, wr_en, wr_num, wr_data, flag_we, flag_in,
    output rd_a_data, rd_b_data, flag_out, wb_pending
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: bypass from the write-back stage, else array select.
module regfile_read_port
  import proc_pkg::*;
(
  input  reg_array_t i_regs,
  input  logic       i_stg_valid,
  input  reg_num_t   i_stg_num,
  input  data_t      i_stg_data,
  input  reg_num_t   i_rd_num,
  output data_t      o_rd_data
);

  logic w_hit;

  assign w_hit     = stage_hit(i_stg_valid, i_stg_num, i_rd_num);
  assign o_rd_data = w_hit ? i_stg_data : i_regs[i_rd_num];

endmodule

// File: rtl/register_file.sv
// Eight-entry general-purpose register file with a one-deep write-back stage,
// stage bypass on both read ports, and the architectural condition flag.
module register_file
  import proc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  register_file_if.slave  bus
);

  reg_array_t r_regs;
  logic       r_stg_valid;
  reg_num_t   r_stg_num;
  data_t      r_stg_data;
  logic       r_flag;

  // The stage commits on the same edge it is refilled, so back-to-back writes
  // to one register retire in order and the newer value is the one bypassed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs      <= '0;
      r_stg_valid <= 1'b0;
      r_stg_num   <= '0;
      r_stg_data  <= '0;
      r_flag      <= 1'b0;
    end else begin
      if (r_stg_valid) begin
        r_regs[r_stg_num] <= r_stg_data;
      end
      r_stg_valid <= bus.wr_en;
      if (bus.wr_en) begin
        r_stg_num  <= bus.wr_num;
        r_stg_data <= bus.wr_data;
      end
      if (bus.flag_we) begin
        r_flag <= bus.flag_in;
      end
    end
  end

  regfile_read_port u_read_a (
    .i_regs      (r_regs),
    .i_stg_valid (r_stg_valid),
    .i_stg_num   (r_stg_num),
    .i_stg_data  (r_stg_data),
    .i_rd_num    (bus.rd_a_num),
    .o_rd_data   (bus.rd_a_data)
  );

  regfile_read_port u_read_b (
    .i_regs      (r_regs),
    .i_stg_valid (r_stg_valid),
    .i_stg_num   (r_stg_num),
    .i_stg_data  (r_stg_data),
    .i_rd_num    (bus.rd_b_num),
    .o_rd_data   (bus.rd_b_data)
  );

  assign bus.flag_out   = r_flag;
  assign bus.wb_pending = r_stg_valid;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vectors with literal expectations
// plus a per-cycle comparison against an architectural model.
module tb_register_file;

  logic clk;
  logic rst_n;

  register_file_if bus ();

  register_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Architectural view: a write requested in cycle k is readable from cycle k+1 on.
  logic [7:0] m_regs [8];
  logic       m_pend;
  logic       m_flag;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_pend = 1'b0;
    m_flag = 1'b0;
  endtask

  task automatic model_edge();
    if (rst_n) begin
      if (bus.wr_en) m_regs[bus.wr_num] = bus.wr_data;
      m_pend = bus.wr_en;
      if (bus.flag_we) m_flag = bus.flag_in;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("model rd_a", bus.rd_a_data, m_regs[bus.rd_a_num]);
    chk("model rd_b", bus.rd_b_data, m_regs[bus.rd_b_num]);
    chk("model flag", {7'd0, bus.flag_out}, {7'd0, m_flag});
    chk("model wb_pending", {7'd0, bus.wb_pending}, {7'd0, m_pend});
  endtask

  // Sample mid-cycle on the falling edge; inputs are changed 1 after the rising edge.
  task automatic half();
    @(negedge clk);
    compare_model();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en   = 1'b0;
    bus.wr_num  = 3'd0;
    bus.wr_data = 8'h00;
    bus.flag_we = 1'b0;
    bus.flag_in = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    idle_inputs();
    bus.rd_a_num = 3'd0;
    bus.rd_b_num = 3'd0;
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset with a staged write and a set flag.
    bus.wr_en = 1'b1; bus.wr_num = 3'd3; bus.wr_data = 8'h5A;
    bus.flag_we = 1'b1; bus.flag_in = 1'b1;
    bus.rd_a_num = 3'd3; bus.rd_b_num = 3'd3;
    half();
    chk("rst pre-write r3", bus.rd_a_data, 8'h00);
    edge_step();
    idle_inputs();
    half();
    chk("rst staged bypass", bus.rd_a_data, 8'h5A);
    chk("rst staged pending", {7'd0, bus.wb_pending}, 8'h01);
    chk("rst flag set", {7'd0, bus.flag_out}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst async pending", {7'd0, bus.wb_pending}, 8'h00);
    chk("rst async flag", {7'd0, bus.flag_out}, 8'h00);
    chk("rst async rd_a", bus.rd_a_data, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    half();
    chk("rst r3 discarded", bus.rd_a_data, 8'h00);
    edge_step();
    half();
    chk("rst r3 stays zero", bus.rd_b_data, 8'h00);
    edge_step();

    // Write-then-read timing on r5.
    bus.wr_en = 1'b1; bus.wr_num = 3'd5; bus.wr_data = 8'hC3; bus.rd_a_num = 3'd5;
    half();
    chk("wr c1 old value", bus.rd_a_data, 8'h00);
    edge_step();
    idle_inputs();
    half();
    chk("wr c2 bypass", bus.rd_a_data, 8'hC3);
    chk("wr c2 pending", {7'd0, bus.wb_pending}, 8'h01);
    edge_step();
    half();
    chk("wr c3 array", bus.rd_a_data, 8'hC3);
    chk("wr c3 pending", {7'd0, bus.wb_pending}, 8'h00);
    edge_step();

    // Back-to-back writes to r2.
    bus.wr_en = 1'b1; bus.wr_num = 3'd2; bus.wr_data = 8'h11; bus.rd_a_num = 3'd2;
    half();
    edge_step();
    bus.wr_data = 8'h22;
    half();
    chk("b2b c2", bus.rd_a_data, 8'h11);
    chk("b2b c2 pending", {7'd0, bus.wb_pending}, 8'h01);
    edge_step();
    idle_inputs();
    half();
    chk("b2b c3", bus.rd_a_data, 8'h22);
    chk("b2b c3 pending", {7'd0, bus.wb_pending}, 8'h01);
    edge_step();
    half();
    chk("b2b c4", bus.rd_a_data, 8'h22);
    chk("b2b c4 pending", {7'd0, bus.wb_pending}, 8'h00);
    edge_step();

    // Dual port, different registers: r0 from the array, r7 from the stage.
    bus.wr_en = 1'b1; bus.wr_num = 3'd0; bus.wr_data = 8'hFF;
    half();
    edge_step();
    bus.wr_num = 3'd7; bus.wr_data = 8'h80;
    half();
    edge_step();
    idle_inputs();
    bus.rd_a_num = 3'd0; bus.rd_b_num = 3'd7;
    half();
    chk("dual A r0", bus.rd_a_data, 8'hFF);
    chk("dual B r7", bus.rd_b_data, 8'h80);
    bus.rd_a_num = 3'd7;
    #1;
    chk("dual A on r7", bus.rd_a_data, 8'h80);
    chk("dual B on r7", bus.rd_b_data, 8'h80);
    edge_step();

    // Flag update and hold.
    bus.flag_we = 1'b1; bus.flag_in = 1'b1;
    half();
    chk("flag c1", {7'd0, bus.flag_out}, 8'h00);
    edge_step();
    bus.flag_we = 1'b0; bus.flag_in = 1'b0;
    half();
    chk("flag c2", {7'd0, bus.flag_out}, 8'h01);
    edge_step();
    half();
    chk("flag c3", {7'd0, bus.flag_out}, 8'h01);
    edge_step();

    // Random traffic against the model.
    for (int n = 0; n < 10000; n++) begin
      bus.wr_en    = 1'($urandom_range(0, 1));
      bus.wr_num   = 3'($urandom_range(0, 7));
      bus.wr_data  = 8'($urandom);
      bus.flag_we  = ($urandom_range(0, 3) == 0);
      bus.flag_in  = 1'($urandom_range(0, 1));
      bus.rd_a_num = 3'($urandom_range(0, 7));
      bus.rd_b_num = ($urandom_range(0, 3) == 0) ? bus.wr_num : 3'($urandom_range(0, 7));
      half();
      edge_step();
    end

    idle_inputs();
    half();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Eight-entry, 8-bit general-purpose register file for the single-cycle/short-pipeline core. It consumes the write-register number produced by the write-register-select mux in decode and provides two combinational read ports to the ALU operand path. Writes are retired through a one-deep write-back staging register, with read bypass from that stage, so the write path is registered while reads stay coherent. It also holds the architectural condition flag.

## Interface
Parameters:
- `DATA_W`, 8: register and data width.
- `REG_N`, 8: number of registers.
- `NUM_W`, 3: register-number width, equal to $clog2(REG_N).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `rd_a_num`  in  NUM_W  read port A register number.
- `rd_b_num`  in  NUM_W  read port B register number.
- `rd_a_data`  out  DATA_W  read port A data (combinational).
- `rd_b_data`  out  DATA_W  read port B data (combinational).
- `wr_en`  in  1  write request this cycle.
- `wr_num`  in  NUM_W  destination register number, driven by the write-register-select mux.
- `wr_data`  in  DATA_W  write data.
- `flag_we`  in  1  flag update request.
- `flag_in`  in  1  new flag value.
- `flag_out`  out  1  current architectural flag.
- `wb_pending`  out  1  staging register holds an uncommitted write (debug/verification).

## Operation
- State:
  - `regs[REG_N]`: the register array.
  - Staging register `{stg_valid, stg_num, stg_data}`.
  - `flag`.
- Each rising edge:
  - If `stg_valid`, commit `regs[stg_num] <= stg_data`.
  - Then `stg_valid <= wr_en`, `stg_num <= wr_num`, `stg_data <= wr_data`. Capture `stg_num` and `stg_data` only when `wr_en` is high; hold them otherwise.
- Read A and read B are independent and identical:
  - `rd_x_data = (stg_valid && stg_num == rd_x_num) ? stg_data : regs[rd_x_num]`.
  - There is no same-cycle bypass from `wr_data`. A read in the same cycle as the write request returns the old value.
- Back-to-back writes to the same register: the later value wins. The older write commits on the same edge that the newer one is staged, and bypass returns the staged (newer) value.
- Simultaneous commit and read of the same register: the bypass is from the stage only. After the edge, the array already holds the value, so reads are consistent.
- Both read ports may address the same register, or the staged register, at once. Both return the same value.
- All registers, including r0, are writable. There is no hardwired zero.
- Flag: `flag <= flag_in` on an edge with `flag_we`; otherwise it holds. `flag_out = flag`, with no bypass.
- Reset (`rst_n` low, asynchronous, at any time):
  - All `regs` = 0, `stg_valid` = 0, `stg_num` = 0, `stg_data` = 0, `flag` = 0.
  - A staged but uncommitted write is discarded.
  - The first edge after `rst_n` rises behaves as a normal edge.
- Output values under reset: `rd_a_data` = `rd_b_data` = 0, `flag_out` = 0, `wb_pending` = 0.

## Timing
- Read latency: 0 cycles (combinational from number to data).
- Write visibility: a request in cycle k (sampled at the end of cycle k):
  - is visible via bypass throughout cycle k+1;
  - is visible from the array from cycle k+2 onward.
- `wb_pending` = `stg_valid`. It is high for exactly one cycle per isolated write and stays high continuously during back-to-back writes.
- Flag: an update in cycle k is visible on `flag_out` in cycle k+1.
- No stalls or backpressure. A write is accepted every cycle.

## Structure
- Shared package `proc_pkg` holds:
  - `DATA_W`, `REG_N`, `NUM_W`;
  - `typedef logic [NUM_W-1:0] reg_num_t`;
  - `typedef logic [DATA_W-1:0] data_t`.
- The write-register-select mux and the decoder use `reg_num_t`.
- One sub-module: `regfile_read_port`, the bypass compare plus array select. Instantiate it twice, once for A and once for B.
- The array, staging register and flag live in `register_file`.

## Test plan
- Reset:
  - Stimulus: assert `rst_n`=0 mid-cycle with a write staged (`wr_en`=1, num 3, data 0x5A the previous cycle).
  - Response: immediately `wb_pending`=0 and `flag_out`=0; after release, reading r3 returns 0x00.
- Write-then-read timing:
  - Stimulus: write r5=0xC3 in cycle 1; read r5 on port A in cycles 1, 2 and 3.
  - Response: 0x00, then 0xC3 (bypass, `wb_pending`=1), then 0xC3 (array, `wb_pending`=0).
- Back-to-back writes to the same register:
  - Stimulus: write r2=0x11 in cycle 1 and r2=0x22 in cycle 2.
  - Response: cycle 2 read 0x11, cycle 3 read 0x22, cycle 4 read 0x22; `wb_pending` high in cycles 2–3.
- Dual-port and different registers:
  - Stimulus: write r0=0xFF in cycle 1 and r7=0x80 in cycle 2; in cycle 3 read A=r0, B=r7.
  - Response: A=0xFF (array), B=0x80 (bypass). Both ports on r7 return 0x80.
- Flag:
  - Stimulus: `flag_we`=1, `flag_in`=1 in cycle 1, then `flag_we`=0, `flag_in`=0 in cycle 2.
  - Response: `flag_out` 0 in cycle 1, then 1 in cycles 2 and 3.
- Random: 10k cycles of random reads and writes against a reference model with the two-stage visibility rule. Zero mismatches are required.
